// File: rtl/gf2_poly_div.sv
// rtl/gf2_poly_div.sv - bit-serial GF(2)[x] long divider, optional radix-2 via GF2_POLY_DIV_RADIX2_EN
module gf2_poly_div #(
   parameter int N_A = 31,
   parameter int N_B = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_A-1:0] dividend,
   input  logic [N_B-1:0] divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N_A-1:0] quotient,
   output logic [N_B-2:0] remainder,
   output logic           div_err
);

   localparam int DW = $clog2(N_B);
   localparam int CW = $clog2(N_A + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t         state, state_nx;
   logic [N_A-1:0] dvd_r;
   logic [N_B-1:0] dvs_r;
   logic [DW-1:0]  deg_r, deg_c;
   logic [N_B-2:0] rem_r, rem_nx;
   logic [N_A-1:0] quo_r, quo_nx;
   logic [CW-1:0]  cnt, cnt_init, cnt_nx;
   logic           last;
   logic [N_B-1:0] s1;

   // One reduction step: shift in a dividend bit, subtract (XOR) divisor when the
   // leading term lines up. Returns {quotient bit, new remainder}.
   function automatic logic [N_B-1:0] step(input logic [N_B-2:0] r, input logic b,
                                           input logic [N_B-1:0] d, input logic [DW-1:0] dg);
      logic [N_B-1:0] t;
      logic [N_B-2:0] rn;
      logic           qb;
      t  = {r, b};
      qb = t[dg];
      if (qb) t = t ^ d;
      for (int i = 0; i < N_B - 1; i++) rn[i] = t[i] & (i < int'(dg));
      return {qb, rn};
   endfunction

   // Priority encoder: degree of the latched divisor
   always_comb begin
      deg_c = '0;
      for (int i = 0; i < N_B; i++) begin
         if (dvs_r[i]) deg_c = DW'(i);
      end
   end

`ifdef GF2_POLY_DIV_RADIX2_EN
   logic [N_A:0]   dvd_p;
   logic [N_B-1:0] s2;
   logic [CW-1:0]  cnt_m1;

   // Two cascaded steps per edge over the MSB-zero-padded dividend
   always_comb begin
      dvd_p    = {1'b0, dvd_r};
      cnt_m1   = cnt - CW'(1);
      s1       = step(rem_r, dvd_p[cnt], dvs_r, deg_r);
      s2       = step(s1[N_B-2:0], dvd_p[cnt_m1], dvs_r, deg_r);
      rem_nx   = s2[N_B-2:0];
      quo_nx   = {quo_r[N_A-3:0], s1[N_B-1], s2[N_B-1]};
      last     = (cnt == CW'(1));
      cnt_init = CW'(N_A);
      cnt_nx   = cnt - CW'(2);
   end
`else
   // One step per edge, dividend MSB first
   always_comb begin
      s1       = step(rem_r, dvd_r[cnt], dvs_r, deg_r);
      rem_nx   = s1[N_B-2:0];
      quo_nx   = {quo_r[N_A-2:0], s1[N_B-1]};
      last     = (cnt == '0);
      cnt_init = CW'(N_A - 1);
      cnt_nx   = cnt - CW'(1);
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = LOAD;
         end
         LOAD:    state_nx = (dvs_r == '0) ? DONE : RUN;
         RUN:     if (last) state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand latch, division shift registers, result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_r     <= '0;
         dvs_r     <= '0;
         deg_r     <= '0;
         rem_r     <= '0;
         quo_r     <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd_r <= dividend;
                  dvs_r <= divisor;
                  rem_r <= '0;
                  quo_r <= '0;
               end
            end
            LOAD: begin
               deg_r <= deg_c;
               cnt   <= cnt_init;
               if (dvs_r == '0) begin
                  quotient  <= '0;
                  remainder <= '0;
                  div_err   <= 1'b1;
               end
            end
            RUN: begin
               rem_r <= rem_nx;
               quo_r <= quo_nx;
               cnt   <= cnt_nx;
               if (last) begin
                  quotient  <= quo_nx;
                  remainder <= rem_nx;
                  div_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
